// File: rtl/wos_line_feeder.sv
// Line feeder for the rank-order filter: buffers one line, then replays it as a
// gap-free burst with HALF edge-padding samples on each side. Optional: WOS_ZERO_PAD_EN.
module wos_line_feeder #(
    parameter int N         = 3,
    parameter int data_bits = 8,
    parameter int LINE_MAX  = 64,
    parameter int len_bits  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [data_bits-1:0] i_data,
    input  logic                 i_valid,
    input  logic                 i_last,
    output logic                 i_ready,
    output logic [data_bits-1:0] o_new,
    output logic                 o_win_valid,
    output logic                 o_win_last,
    output logic                 o_busy
);
    localparam int HALF = (N - 1) / 2;
    localparam int AW   = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
    localparam logic [len_bits-1:0] HALF_L = len_bits'(HALF);
    localparam logic [len_bits-1:0] TWO_H  = len_bits'(2 * HALF);
    localparam logic [len_bits-1:0] LAST_W = len_bits'(LINE_MAX - 1);
    localparam logic [len_bits-1:0] ONE    = len_bits'(1);

    typedef enum logic [1:0] {ACCEPT, PRE, STREAM, POST} state_t;

    state_t                state, state_nx;
    logic [len_bits-1:0]   len, len_nx;
    logic [len_bits-1:0]   e, e_nx;
    logic [len_bits-1:0]   e_end;
    logic [AW-1:0]         rd_idx;
    logic                  emit;
    logic                  take;
    logic [data_bits-1:0]  src;
    logic [data_bits-1:0]  mem [LINE_MAX];
`ifdef WOS_ZERO_PAD_EN
    logic                  pad;
`endif

    assign e_end = len + TWO_H - ONE;
    // o_busy still covers the final POST output, so the line buffer stays
    // closed until that sample has been presented downstream.
    assign i_ready = (state == ACCEPT) && !o_busy;
    assign take    = i_valid && i_ready;

    always_comb begin
        state_nx = state;
        len_nx   = len;
        e_nx     = e;
        rd_idx   = '0;
        emit     = 1'b0;
`ifdef WOS_ZERO_PAD_EN
        pad      = 1'b0;
`endif
        unique case (state)
            ACCEPT: begin
                if (take) begin
                    len_nx = len + ONE;
                    if (i_last || len == LAST_W) state_nx = PRE;
                end
            end
            PRE: begin
                emit = 1'b1;
`ifdef WOS_ZERO_PAD_EN
                pad  = 1'b1;
`endif
                e_nx = e + ONE;
                if (e == HALF_L - ONE) state_nx = STREAM;
            end
            STREAM: begin
                emit   = 1'b1;
                rd_idx = AW'(e - HALF_L);
                e_nx   = e + ONE;
                if (e == HALF_L + len - ONE) state_nx = POST;
            end
            POST: begin
                emit   = 1'b1;
`ifdef WOS_ZERO_PAD_EN
                pad    = 1'b1;
`endif
                rd_idx = AW'(len - ONE);
                if (e == e_end) begin
                    state_nx = ACCEPT;
                    e_nx     = '0;
                    len_nx   = '0;
                end else begin
                    e_nx = e + ONE;
                end
            end
        endcase
    end

`ifdef WOS_ZERO_PAD_EN
    assign src = pad ? '0 : mem[rd_idx];
`else
    assign src = mem[rd_idx];
`endif

    always_ff @(posedge clk) begin
        if (take) mem[AW'(len)] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCEPT;
            len   <= '0;
            e     <= '0;
        end else begin
            state <= state_nx;
            len   <= len_nx;
            e     <= e_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_new       <= '0;
            o_win_valid <= 1'b0;
            o_win_last  <= 1'b0;
            o_busy      <= 1'b0;
        end else if (emit) begin
            o_new       <= src;
            o_win_valid <= (e >= TWO_H);
            o_win_last  <= (e == e_end);
            o_busy      <= 1'b1;
        end else begin
            o_win_valid <= 1'b0;
            o_win_last  <= 1'b0;
            o_busy      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wos_line_feeder.sv
// Directed bench for wos_line_feeder: an N=3 and an N=5 instance share the clock
// and reset; sel chooses which one is driven and observed.
module tb_wos_line_feeder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = '0;
    logic       vld = 1'b0;
    logic       last = 1'b0;
    logic       sel = 1'b0;

    logic       v3, v5, r3, r5, wv3, wv5, wl3, wl5, b3, b5;
    logic [7:0] n3, n5;
    logic [7:0] new_s;
    logic       rdy_s, wv_s, wl_s, busy_s;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign v3     = vld & ~sel;
    assign v5     = vld & sel;
    assign new_s  = sel ? n5 : n3;
    assign rdy_s  = sel ? r5 : r3;
    assign wv_s   = sel ? wv5 : wv3;
    assign wl_s   = sel ? wl5 : wl3;
    assign busy_s = sel ? b5 : b3;

    wos_line_feeder #(.N(3), .data_bits(8), .LINE_MAX(64), .len_bits(7)) dut3 (
        .clk(clk), .rst(rst), .i_data(data), .i_valid(v3), .i_last(last),
        .i_ready(r3), .o_new(n3), .o_win_valid(wv3), .o_win_last(wl3), .o_busy(b3)
    );

    wos_line_feeder #(.N(5), .data_bits(8), .LINE_MAX(64), .len_bits(7)) dut5 (
        .clk(clk), .rst(rst), .i_data(data), .i_valid(v5), .i_last(last),
        .i_ready(r5), .o_new(n5), .o_win_valid(wv5), .o_win_last(wl5), .o_busy(b5)
    );

    function automatic logic [7:0] padv(input logic [7:0] edge_val);
`ifdef WOS_ZERO_PAD_EN
        return 8'd0;
`else
        return edge_val;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic lst);
        chk("push_ready", 32'(rdy_s), 32'd1);
        data = d;
        last = lst;
        vld  = 1'b1;
        @(negedge clk);
        vld  = 1'b0;
        last = 1'b0;
    endtask

    // Called at the negedge right after the last sample was accepted.
    task automatic burst(input int h);
        int b;
        b = exp_q.size();
        chk("gap_ready", 32'(rdy_s), 32'd0);
        chk("gap_busy", 32'(busy_s), 32'd0);
        for (int i = 0; i < b; i++) begin
            @(negedge clk);
            chk($sformatf("new[%0d]", i), 32'(new_s), 32'(exp_q[i]));
            chk($sformatf("wv[%0d]", i), 32'(wv_s), 32'(i >= 2 * h));
            chk($sformatf("wl[%0d]", i), 32'(wl_s), 32'(i == b - 1));
            chk($sformatf("busy[%0d]", i), 32'(busy_s), 32'd1);
            chk($sformatf("rdy[%0d]", i), 32'(rdy_s), 32'd0);
        end
        @(negedge clk);
        chk("end_busy", 32'(busy_s), 32'd0);
        chk("end_ready", 32'(rdy_s), 32'd1);
        chk("end_wv", 32'(wv_s), 32'd0);
    endtask

    initial begin
        int waits;

        // reset and idle
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready3", 32'(r3), 32'd1);
        chk("rst_new3", 32'(n3), 32'd0);
        chk("rst_wv3", 32'(wv3), 32'd0);
        chk("rst_busy3", 32'(b3), 32'd0);
        chk("rst_ready5", 32'(r5), 32'd1);
        chk("rst_new5", 32'(n5), 32'd0);

        // N=3, line 10,20,30
        sel = 1'b0;
        push(8'd10, 1'b0);
        push(8'd20, 1'b0);
        push(8'd30, 1'b1);
        exp_q = '{padv(8'd10), 8'd10, 8'd20, 8'd30, padv(8'd30)};
        burst(1);
        chk("hold_new", 32'(n3), 32'(padv(8'd30)));

        // N=5, single sample
        sel = 1'b1;
        push(8'd7, 1'b1);
        exp_q = '{padv(8'd7), padv(8'd7), 8'd7, padv(8'd7), padv(8'd7)};
        burst(2);

        // 64 samples without i_last: forced end
        sel = 1'b0;
        for (int i = 0; i < 64; i++) push(8'(i), 1'b0);
        exp_q.delete();
        exp_q.push_back(padv(8'd0));
        for (int i = 0; i < 64; i++) exp_q.push_back(8'(i));
        exp_q.push_back(padv(8'd63));
        burst(1);
        push(8'd99, 1'b1);
        exp_q = '{padv(8'd99), 8'd99, padv(8'd99)};
        burst(1);

        // reset on the 2nd STREAM cycle
        push(8'd1, 1'b0);
        push(8'd2, 1'b0);
        push(8'd3, 1'b1);
        repeat (2) @(negedge clk);
        chk("pre_rst_new", 32'(n3), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_new", 32'(n3), 32'd0);
        chk("mid_rst_wv", 32'(wv3), 32'd0);
        chk("mid_rst_wl", 32'(wl3), 32'd0);
        chk("mid_rst_busy", 32'(b3), 32'd0);
        chk("mid_rst_ready", 32'(r3), 32'd1);
        push(8'd5, 1'b0);
        push(8'd6, 1'b1);
        exp_q = '{padv(8'd5), 8'd5, 8'd6, padv(8'd6)};
        burst(1);

        // back-pressure: valid held through a burst
        push(8'd1, 1'b0);
        push(8'd2, 1'b1);
        data  = 8'd77;
        vld   = 1'b1;
        waits = 0;
        while (!r3 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("bp_wait", 32'(waits), 32'd5);
        @(negedge clk);
        data = 8'd88;
        last = 1'b1;
        @(negedge clk);
        vld  = 1'b0;
        last = 1'b0;
        exp_q = '{padv(8'd77), 8'd77, 8'd88, padv(8'd88)};
        burst(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wos_line_feeder.md
Name: wos_line_feeder

Overview:
- Upstream stage of the rank-order filter datapath.
- Accepts one line of samples over a valid/ready stream and buffers it whole.
- Replays the line to the filter's new-sample input as one bubble-free burst, with (N-1)/2 edge-padding samples before and after the line.
- Flags every cycle on which the filter's N-sample window is centred on a real sample.

Parameters:
N, 3, filter window length; odd, >= 3; HALF = (N-1)/2
data_bits, 8, sample width
LINE_MAX, 64, maximum samples per line (buffer depth)
len_bits, 7, width of length/index counters; must hold LINE_MAX + 2*HALF

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
i_data  input  data_bits  incoming sample
i_valid  input  1  i_data valid
i_last  input  1  qualifies i_data as final sample of the line
i_ready  output  1  block can accept a sample this cycle
o_new  output  data_bits  sample to the filter's new-sample input, one per cycle
o_win_valid  output  1  window ending with this o_new is centred on a real sample
o_win_last  output  1  o_win_valid for the last real sample of the line
o_busy  output  1  burst in progress

Behaviour:
- Transfer: a sample is taken when i_valid && i_ready on a rising edge.
- i_ready is combinational from state: 1 in ACCEPT, 0 otherwise.
- All o_* outputs are registered.
- Reset (rst=1 at an edge):
  - state ACCEPT; write count L=0; emit index e=0.
  - o_new=0, o_win_valid=0, o_win_last=0, o_busy=0.
  - Buffer RAM contents are don't-care.
  - Reset mid-burst aborts the line silently; there is no partial flush.
- ACCEPT:
  - Each transfer writes buf[L] and increments L.
  - Exit to PRE when the transfer has i_last=1, or when it is the LINE_MAX-th sample (forced last; an i_last arriving later starts a new line).
  - o_new holds its last value; o_win_valid=0.
- PRE, HALF cycles: o_new=buf[0]; o_busy=1.
- STREAM, L cycles: o_new=buf[k] for k = 0..L-1 in order.
- POST, HALF cycles: o_new=buf[L-1]. Then return to ACCEPT with L cleared.
  - i_ready returns to 1 the cycle after the last POST output.
- Window flags:
  - e counts emitted outputs across PRE/STREAM/POST, 0 .. L+2*HALF-1.
  - o_win_valid=1 iff e >= 2*HALF, so exactly L cycles per line.
  - o_win_last=1 only on e = L+2*HALF-1.
- Latency: first o_new appears the cycle after the accepting edge of the last sample. The burst length is exactly L+2*HALF cycles with no gaps.
- Filter-internal pipeline delay is not compensated here; the consumer delays o_win_valid by the filter latency.
- L=1: output is buf[0] repeated N times; o_win_valid and o_win_last both high on the final cycle.
- i_valid while not ready is ignored, with no side effects. i_last with i_valid=0 is ignored.

Optional Feature:
- Macro WOS_ZERO_PAD_EN.
- Defined: PRE and POST emit 0 instead of replicating the edge sample. Timing and flags are unchanged.
- Undefined: edge replication as specified above.

Test Plan:
- Reset, then idle: rst high 2 cycles, release.
  - Required: i_ready=1, o_new=0, o_win_valid=0, o_busy=0.
- N=3 line 10,20,30 (i_last on 30).
  - Required: o_new sequence 10,10,20,30,30.
  - Required: o_win_valid 0,0,1,1,1; o_win_last on the 5th output.
  - Required: i_ready=0 for those 5 cycles.
- Single sample 7 with i_last, N=5.
  - Required: o_new 7 x5; o_win_valid only on the 5th output, with o_win_last.
- Line of 64 samples 0..63, no i_last.
  - Required: forced end after sample 63; burst 0,0..63,63.
  - Required: the next sample 99 with i_last forms a new 1-sample line.
- rst asserted on the 2nd cycle of STREAM.
  - Required: outputs return to reset values next cycle.
  - Required: a fresh line 5,6 (i_last on 6) then emits 5,5,6,6.
- WOS_ZERO_PAD_EN defined, line 10,20,30.
  - Required: o_new 0,10,20,30,0; same flags as the non-padded case.
- Back-pressure: i_valid held high during a burst.
  - Required: no sample is taken until i_ready rises; the first accepted sample lands in buf[0].
